// File: rtl/dmem_responder_if.sv
// +--------------------------------------------------------------------+
// | Module   : dmem_responder_if                                       |
// | Desc     : Request/response bus between MEM stage and dmem.        |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
`default_nettype none

interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_wr_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rd_data;
  logic        rsp_error;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_wr_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_rd_data, rsp_error
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_wr_data, rsp_ready,
    output req_ready, rsp_valid, rsp_rd_data, rsp_error
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// +--------------------------------------------------------------------+
// | Module   : dmem_responder                                          |
// | Desc     : Fixed-latency word RAM answering tiny5 load/store reqs. |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
`default_nettype none

module dmem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  dmem_responder_if.slave    bus
);

  localparam int          IDX_W  = ADDR_WIDTH - 2;
  localparam int          WORDS  = 1 << IDX_W;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0]  SZ_BYTE = 2'd0;
  localparam logic [1:0]  SZ_HALF = 2'd1;
  localparam logic [1:0]  SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        capture;
  logic        commit;

  logic [31:0] addr_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_data_q;
  logic        err_q;

  logic [31:0] mem [WORDS];

  logic [IDX_W-1:0] idx;
  logic        acc_err;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] word_rd;
  logic [31:0] word_shift;
  logic [31:0] load_data;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A LATENCY of 1 loads a zero count, so WAIT commits on its first cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          capture   = 1'b1;
          cnt_nxt   = LAT_M1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- Request capture and response registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= 32'd0;
      we_q      <= 1'b0;
      size_q    <= 2'd0;
      wdata_q   <= 32'd0;
      rd_data_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      if (capture) begin
        addr_q  <= bus.req_addr;
        we_q    <= bus.req_we;
        size_q  <= bus.req_size;
        wdata_q <= bus.req_wr_data;
      end
      if (commit) begin
        rd_data_q <= (acc_err || we_q) ? 32'd0 : load_data;
        err_q     <= acc_err;
      end
    end
  end

  // ---------------- Access decode ----------------
  assign idx = addr_q[ADDR_WIDTH-1:2];

  always_comb begin
    acc_err = 1'b0;
    if (size_q == 2'd3)                               acc_err = 1'b1;
    if (size_q == SZ_HALF && addr_q[0])               acc_err = 1'b1;
    if (size_q == SZ_WORD && addr_q[1:0] != 2'b00)    acc_err = 1'b1;
    if ((addr_q >> ADDR_WIDTH) != 32'd0)              acc_err = 1'b1;
  end

  always_comb begin
    be    = 4'b0000;
    wlane = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      SZ_WORD: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    word_rd    = mem[idx];
    word_shift = word_rd >> {addr_q[1:0], 3'b000};
    load_data  = 32'd0;
    case (size_q)
      SZ_BYTE: load_data = {24'd0, word_shift[7:0]};
      SZ_HALF: load_data = {16'd0, word_shift[15:0]};
      SZ_WORD: load_data = word_rd;
      default: load_data = 32'd0;
    endcase
  end

  // RAM has no reset; contents are undefined until stored.
  always_ff @(posedge clk) begin
    if (commit && we_q && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

  // ---------------- Bus outputs ----------------
  assign bus.req_ready   = (state == S_IDLE);
  assign bus.rsp_valid   = (state == S_RESP);
  assign bus.rsp_rd_data = rd_data_q;
  assign bus.rsp_error   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// +--------------------------------------------------------------------+
// | Module   : tb_dmem_responder                                       |
// | Desc     : Directed self-checking bench for dmem_responder.        |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dmem_responder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  dmem_responder_if b2 ();
  dmem_responder_if b1 ();

  dmem_responder #(.ADDR_WIDTH(12), .LATENCY(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.slave)
  );

  dmem_responder #(.ADDR_WIDTH(12), .LATENCY(1)) u_dut_lat1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output logic err, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!b2.rsp_valid && lat < 40);
    if (!b2.rsp_valid) check_val("rsp_timeout", 32'(b2.rsp_valid), 32'd1);
    rd  = b2.rsp_rd_data;
    err = b2.rsp_error;
  endtask

  // Presents one request, waits for acceptance, deasserts valid right after.
  task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wd);
    int guard;
    @(negedge clk);
    b2.req_valid   = 1'b1;
    b2.req_we      = we;
    b2.req_size    = size;
    b2.req_addr    = addr;
    b2.req_wr_data = wd;
    guard = 0;
    while (!b2.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!b2.req_ready) check_val("accept_timeout", 32'(b2.req_ready), 32'd1);
    @(posedge clk);
    #1;
    b2.req_valid = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    int          lat;
    issue(we, size, addr, wd);
    wait_rsp(rd, err, lat);
    check_val({tag, "_rd"},  rd, exp_rd);
    check_val({tag, "_err"}, 32'(err), 32'(exp_err));
    check_val({tag, "_lat"}, 32'(lat), 32'd2);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;

    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_size = 2'd0;
    b2.req_addr  = 32'd0; b2.req_wr_data = 32'd0; b2.rsp_ready = 1'b1;
    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_size = 2'd0;
    b1.req_addr  = 32'd0; b1.req_wr_data = 32'd0; b1.rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_req_ready", 32'(b2.req_ready), 32'd1);
    check_val("rst_rsp_valid", 32'(b2.rsp_valid), 32'd0);
    check_val("rst_rd_data",   b2.rsp_rd_data,    32'd0);
    check_val("rst_error",     32'(b2.rsp_error), 32'd0);
    rst_n = 1'b1;

    // LATENCY=1 instance: loads held back-to-back, accepts every 3rd edge.
    b1.req_valid = 1'b1;
    b1.req_size  = 2'd2;
    b1.req_addr  = 32'h40;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      check_val($sformatf("lat1_ready_%0d", k), 32'(b1.req_ready), 32'((k % 3) == 0));
      check_val($sformatf("lat1_valid_%0d", k), 32'(b1.rsp_valid), 32'((k % 3) == 2));
      if (k % 3 == 2) check_val($sformatf("lat1_err_%0d", k), 32'(b1.rsp_error), 32'd0);
    end
    b1.req_valid = 1'b0;

    // Word write / read back
    do_op("sw_10", 1'b1, 2'd2, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0);
    do_op("lw_10", 1'b0, 2'd2, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0);

    // Byte and half lanes
    do_op("sw_20",  1'b1, 2'd2, 32'h020, 32'h11223344, 32'h0,        1'b0);
    do_op("sb_21",  1'b1, 2'd0, 32'h021, 32'h000000AA, 32'h0,        1'b0);
    do_op("sh_22",  1'b1, 2'd1, 32'h022, 32'h0000BEEF, 32'h0,        1'b0);
    do_op("lw_20",  1'b0, 2'd2, 32'h020, 32'h0,        32'hBEEFAA44, 1'b0);
    do_op("lbu_23", 1'b0, 2'd0, 32'h023, 32'h0,        32'h000000BE, 1'b0);
    do_op("lhu_20", 1'b0, 2'd1, 32'h020, 32'h0,        32'h0000AA44, 1'b0);

    // Error cases; word 0 must survive the out-of-range store that aliases it
    do_op("sw_00",   1'b1, 2'd2, 32'h000,  32'hA5A55A5A, 32'h0,        1'b0);
    do_op("e_lw22",  1'b0, 2'd2, 32'h022,  32'h0,        32'h0,        1'b1);
    do_op("e_sh11",  1'b1, 2'd1, 32'h011,  32'h0000FFFF, 32'h0,        1'b1);
    do_op("e_sz3",   1'b0, 2'd3, 32'h000,  32'h0,        32'h0,        1'b1);
    do_op("e_oor",   1'b1, 2'd2, 32'h1000, 32'h12345678, 32'h0,        1'b1);
    do_op("lw_00",   1'b0, 2'd2, 32'h000,  32'h0,        32'hA5A55A5A, 1'b0);
    do_op("lw_10b",  1'b0, 2'd2, 32'h010,  32'h0,        32'hDEADBEEF, 1'b0);

    // Response backpressure with a second request waiting
    @(negedge clk);
    b2.rsp_ready = 1'b0;
    issue(1'b0, 2'd2, 32'h010, 32'h0);
    wait_rsp(rd, err, lat);
    check_val("bp_first_rd",  rd, 32'hDEADBEEF);
    check_val("bp_first_lat", 32'(lat), 32'd2);
    b2.req_valid = 1'b1;
    b2.req_we    = 1'b0;
    b2.req_size  = 2'd2;
    b2.req_addr  = 32'h020;
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("bp_valid_%0d", i), 32'(b2.rsp_valid), 32'd1);
      check_val($sformatf("bp_rd_%0d", i),    b2.rsp_rd_data,    32'hDEADBEEF);
      check_val($sformatf("bp_ready_%0d", i), 32'(b2.req_ready), 32'd0);
      @(negedge clk);
    end
    b2.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("bp_hs_valid", 32'(b2.rsp_valid), 32'd0);
    check_val("bp_hs_ready", 32'(b2.req_ready), 32'd1);
    @(posedge clk);
    #1;
    check_val("bp_accepted", 32'(b2.req_ready), 32'd0);
    b2.req_valid = 1'b0;
    wait_rsp(rd, err, lat);
    check_val("bp_second_rd",  rd, 32'hBEEFAA44);
    check_val("bp_second_lat", 32'(lat), 32'd2);

    // Reset one cycle after accepting a store: write must be dropped
    do_op("sw_30", 1'b1, 2'd2, 32'h030, 32'h01020304, 32'h0, 1'b0);
    issue(1'b1, 2'd2, 32'h030, 32'hCAFEF00D);
    check_val("rw_in_wait", 32'(b2.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("rw_rsp_valid", 32'(b2.rsp_valid), 32'd0);
    check_val("rw_req_ready", 32'(b2.req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("lw_30", 1'b0, 2'd2, 32'h030, 32'h0, 32'h01020304, 1'b0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the tiny5 pipeline. It answers load/store requests issued by the MEM stage (size encoded as `mem_access_size_t`) from an on-chip word-organised RAM with a parameterisable fixed latency. It returns zero-extended load data; the core's WB stage applies SEXT8/SEXT16. It sits on the far side of the MEM stage's dmem interface and is used in both simulation and FPGA builds.

## Interface
- `ADDR_WIDTH`, 12: byte-address bits decoded. RAM holds 2^(ADDR_WIDTH-2) 32-bit words.
- `LATENCY`, 2: cycles from request acceptance to `rsp_valid_o`. Legal range is 1..15.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  responder can accept a request.
- `req_addr_i`  in  32  byte address.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  `mem_access_size_t`: BYTE=0, HALF=1, WORD=2. The value 3 is illegal.
- `req_wr_data_i`  in  32  store data, right-aligned.
- `rsp_valid_o`  out  1  response present.
- `rsp_ready_i`  in  1  consumer accepts response.
- `rsp_rd_data_o`  out  32  load data, zero-extended and right-aligned. It is 0 for stores and errors.
- `rsp_error_o`  out  1  request was misaligned, out of range, or had an illegal size.

## Operation
- FSM states are IDLE, WAIT, and RESP. There is one outstanding request at most.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i`, the request is accepted. Address, we, size, and wr_data are captured, the latency counter is loaded with LATENCY-1, and the FSM moves to WAIT. If LATENCY=1, it goes directly to the commit step.
- WAIT:
  - `req_ready_o`=0.
  - The counter decrements each cycle.
  - When the counter is 0, the commit step executes and the FSM moves to RESP.
- Commit step (single cycle, on the transition into RESP):
  - Error is set if any of the following holds: size=3; HALF with addr[0]=1; WORD with addr[1:0]!=0; addr[31:ADDR_WIDTH]!=0.
  - Error: no RAM write, rd_data=0, error=1.
  - Store: the word at addr[ADDR_WIDTH-1:2] is written under byte enables.
    - BYTE writes lane addr[1:0] with wr_data[7:0].
    - HALF writes lanes {addr[1],0} and {addr[1],1} with wr_data[15:0].
    - WORD writes all lanes.
    - Other lanes are unchanged. rd_data=0.
  - Load:
    - BYTE returns {24'b0, lane addr[1:0]}.
    - HALF returns {16'b0, half addr[1]}.
    - WORD returns the full word.
- RESP:
  - `rsp_valid_o`=1. Data and error are held stable until `rsp_ready_i`=1.
  - On handshake, the FSM goes to IDLE. `req_ready_o` rises the next cycle.
- A request with `req_valid_i` asserted while `req_ready_o`=0 is not accepted. The requester holds it, and it is accepted on return to IDLE.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values:
  - FSM is in IDLE.
  - `req_ready_o`=1.
  - `rsp_valid_o`=0.
  - `rsp_rd_data_o`=0.
  - `rsp_error_o`=0.
  - Counter is 0.
- Accept on edge t means `rsp_valid_o`=1 from edge t+LATENCY.
- With `rsp_ready_i` held high, the response handshake happens at edge t+LATENCY+1, and the next accept is possible at edge t+LATENCY+2.
- Peak throughput is one request per LATENCY+2 cycles.
- A store is visible to a load accepted at any later time. The store commit precedes the earliest next accept.
- Reset asserted mid-WAIT:
  - The request is dropped and no write occurs.
  - The FSM goes to IDLE immediately, because reset is asynchronous.
- Reset asserted in RESP: the pending response is discarded, and the already-committed write persists.
- `rsp_ready_i` held low indefinitely: the FSM stays in RESP, outputs stay constant, and `req_ready_o` stays 0.

## Test plan
- Write and read back a word:
  - Stimulus: SW 0xDEADBEEF @0x010, then LW @0x010, with LATENCY=2.
  - Required: rd_data=0xDEADBEEF, error=0, and `rsp_valid_o` exactly 2 cycles after each accept.
- Byte and half lanes:
  - Stimulus: SW 0x11223344 @0x020, then SB 0xAA @0x021, then SH 0xBEEF @0x022.
  - Required: LW @0x020 returns 0xBEEFAA44. LBU @0x023 returns 0x000000BE. LHU @0x020 returns 0x0000AA44.
- Error cases:
  - Stimulus: LW @0x022; SH @0x011; LB with size=3; SW 0x12345678 @0x1000 (out of range, ADDR_WIDTH=12).
  - Required: each returns error=1 and rd_data=0. A following LW @0x000 shows no corruption.
- Response backpressure:
  - Stimulus: hold `rsp_ready_i`=0 for 5 cycles in RESP while a second request is presented.
  - Required: rsp_data is stable, `req_ready_o`=0, and the second request is accepted exactly 1 cycle after the handshake.
- Reset mid-WAIT:
  - Stimulus: SW 0xCAFEF00D @0x030 over existing 0x01020304, with reset pulsed 1 cycle after accept.
  - Required: immediately `rsp_valid_o`=0 and `req_ready_o`=1, and LW @0x030 returns 0x01020304.
- LATENCY=1 build:
  - Stimulus: back-to-back loads with `rsp_ready_i`=1.
  - Required: `rsp_valid_o` 1 cycle after accept, and accepts spaced every 3 cycles.
